// File: rtl/ara_axi_rd_responder.sv
// ----------------------------------------------------------------------------
// ara_axi_rd_responder
//   AXI4 read-channel responder (slave end). Accepts one AR burst at a time,
//   walks the FIXED/INCR/WRAP address sequence, and issues one read per beat to
//   a single-port synchronous memory with 1-cycle read latency. The R channel is
//   backed by a 2-entry FIFO.
//
//   The FIFO write port is transparent: a read that is in flight is presented
//   on R in the cycle its data returns if the FIFO is empty. This gives a first
//   R beat two cycles after the AR handshake. A beat that is not accepted that
//   cycle lands in the FIFO unchanged, so the R fields stay stable under stall.
//
//   Illegal bursts complete as SLVERR bursts. They produce no memory access,
//   return zero data, and keep the same beat count and pacing.
//
//   Optional feature: define ARA_AXI_RSP_4K_CHECK_EN to turn any INCR burst
//   whose last byte falls in a different 4 KiB page than its start address into
//   an SLVERR burst. The default build lets such bursts read memory normally.
// ----------------------------------------------------------------------------
module ara_axi_rd_responder #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiIdWidth   = 5,
  parameter int unsigned MemAddrWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // AR channel
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  // R channel
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  // Memory read port
  output logic                    mem_req_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  input  logic [AxiDataWidth-1:0] mem_rdata_i,
  // Status
  output logic                    busy_o
);

  localparam int unsigned kBytesPerWord = AxiDataWidth / 8;
  localparam int unsigned kByteShift    = $clog2(kBytesPerWord);

  localparam logic [AxiAddrWidth-1:0] kAddrOne = AxiAddrWidth'(1);

  localparam logic [1:0] kBurstFixed = 2'b00;
  localparam logic [1:0] kBurstIncr  = 2'b01;
  localparam logic [1:0] kBurstWrap  = 2'b10;
  localparam logic [1:0] kBurstRsvd  = 2'b11;

  localparam logic [1:0] kRespOkay   = 2'b00;
  localparam logic [1:0] kRespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DRAIN
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                  r_state;
  logic                    r_ar_ready;
  logic [AxiIdWidth-1:0]   r_id;
  logic [AxiAddrWidth-1:0] r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic                    r_err;
  logic [8:0]              r_issued;
  logic                    r_inflight;
  logic                    r_inflight_last;

  logic [1:0]              r_fifo_count;
  logic [AxiDataWidth-1:0] r_fifo_data [2];
  logic [1:0]              r_fifo_resp [2];
  logic                    r_fifo_last [2];

  // --------------------------------------------------------------------------
  // AR decode: legality checks on the incoming request
  // --------------------------------------------------------------------------
  logic [AxiAddrWidth-1:0] w_ar_bytes;
  logic                    w_ar_wrap_len_ok;
  logic                    w_ar_wrap_bad;
  logic                    w_ar_4k_err;
  logic                    w_ar_err;
  logic                    w_ar_fire;

  assign w_ar_bytes       = kAddrOne << ar_size_i;
  assign w_ar_wrap_len_ok = ar_len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign w_ar_wrap_bad    = (ar_burst_i == kBurstWrap) &&
                            (!w_ar_wrap_len_ok || ((ar_addr_i & (w_ar_bytes - kAddrOne)) != '0));

`ifdef ARA_AXI_RSP_4K_CHECK_EN
  logic [AxiAddrWidth-1:0] w_ar_last_byte;
  // Last byte touched: aligned start plus the whole burst length, minus one.
  assign w_ar_last_byte = (ar_addr_i & ~(w_ar_bytes - kAddrOne))
                        + ((AxiAddrWidth'(ar_len_i) + kAddrOne) << ar_size_i)
                        - kAddrOne;
  assign w_ar_4k_err    = (ar_burst_i == kBurstIncr) &&
                          (w_ar_last_byte[AxiAddrWidth-1:12] != ar_addr_i[AxiAddrWidth-1:12]);
`else
  assign w_ar_4k_err    = 1'b0;
`endif

  assign w_ar_err  = (ar_burst_i == kBurstRsvd)
                   || (ar_size_i > 3'(kByteShift))
                   || w_ar_wrap_bad
                   || w_ar_4k_err;
  assign w_ar_fire = ar_valid_i && r_ar_ready;

  // --------------------------------------------------------------------------
  // Next beat address for the latched burst
  // --------------------------------------------------------------------------
  logic [AxiAddrWidth-1:0] w_bytes;
  logic [AxiAddrWidth-1:0] w_container;
  logic [AxiAddrWidth-1:0] w_wrap_base;
  logic [AxiAddrWidth-1:0] w_next_addr;

  assign w_bytes     = kAddrOne << r_size;
  assign w_container = (AxiAddrWidth'(r_len) + kAddrOne) << r_size;
  assign w_wrap_base = r_addr & ~(w_container - kAddrOne);

  // Select the address of the following beat according to burst type.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      kBurstFixed: w_next_addr = r_addr;
      kBurstWrap:  w_next_addr = w_wrap_base
                               + ((r_addr + w_bytes - w_wrap_base) & (w_container - kAddrOne));
      default:     w_next_addr = (r_addr & ~(w_bytes - kAddrOne)) + w_bytes;
    endcase
  end

  // --------------------------------------------------------------------------
  // Issue rule: a beat goes out only when FIFO plus in-flight has room, so the
  // 2-entry FIFO can never overflow.
  // --------------------------------------------------------------------------
  logic w_slots_free;
  logic w_issue;
  logic w_issue_last;

  assign w_slots_free = (r_fifo_count + {1'b0, r_inflight}) < 2'd2;
  assign w_issue      = (r_state == ST_BURST) && (r_issued <= {1'b0, r_len}) && w_slots_free;
  assign w_issue_last = (r_issued == {1'b0, r_len});

  assign mem_req_o  = w_issue && !r_err;
  assign mem_addr_o = MemAddrWidth'(r_addr >> kByteShift);

  // --------------------------------------------------------------------------
  // R channel: FIFO head, or the returning read when the FIFO is empty
  // --------------------------------------------------------------------------
  logic                    w_head_in_fifo;
  logic [AxiDataWidth-1:0] w_ret_data;
  logic [1:0]              w_ret_resp;
  logic                    w_pop;
  logic                    w_pop_fifo;
  logic                    w_push;
  logic                    w_push_idx;

  assign w_head_in_fifo = (r_fifo_count != 2'd0);
  assign w_ret_data     = r_err ? '0 : mem_rdata_i;
  assign w_ret_resp     = r_err ? kRespSlvErr : kRespOkay;

  assign r_valid_o  = w_head_in_fifo || r_inflight;
  assign w_pop      = r_valid_o && r_ready_i;
  assign w_pop_fifo = w_pop && w_head_in_fifo;
  // The returning beat is stored unless it leaves directly through R.
  assign w_push     = r_inflight && !(w_pop && !w_head_in_fifo);
  // Write slot after accounting for a simultaneous pop shifting the FIFO.
  assign w_push_idx = w_pop_fifo ? (r_fifo_count == 2'd2) : (r_fifo_count == 2'd1);

  // Drive the R payload from the current head; all zero when nothing is valid.
  always_comb begin
    r_data_o = '0;
    r_resp_o = kRespOkay;
    r_last_o = 1'b0;
    r_id_o   = '0;
    if (w_head_in_fifo) begin
      r_data_o = r_fifo_data[0];
      r_resp_o = r_fifo_resp[0];
      r_last_o = r_fifo_last[0];
      r_id_o   = r_id;
    end else if (r_inflight) begin
      r_data_o = w_ret_data;
      r_resp_o = w_ret_resp;
      r_last_o = r_inflight_last;
      r_id_o   = r_id;
    end
  end

  assign ar_ready_o = r_ar_ready;
  assign busy_o     = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Control FSM, burst registers, in-flight tracking and FIFO occupancy.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the block order does not matter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_ar_ready      <= 1'b0;
      r_id            <= '0;
      r_addr          <= '0;
      r_len           <= '0;
      r_size          <= '0;
      r_burst         <= '0;
      r_err           <= 1'b0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_count    <= '0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;

      case ({w_push, w_pop_fifo})
        2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
        default: r_fifo_count <= r_fifo_count;
      endcase

      case (r_state)
        ST_IDLE: begin
          r_ar_ready <= 1'b1;
          if (w_ar_fire) begin
            r_ar_ready <= 1'b0;
            r_id       <= ar_id_i;
            r_addr     <= ar_addr_i;
            r_len      <= ar_len_i;
            r_size     <= ar_size_i;
            r_burst    <= ar_burst_i;
            r_err      <= w_ar_err;
            r_issued   <= '0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          r_ar_ready <= 1'b0;
          if (w_issue) begin
            r_issued <= r_issued + 9'd1;
            r_addr   <= w_next_addr;
            if (w_issue_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && r_last_o) begin
            r_state    <= ST_IDLE;
            r_ar_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ar_ready <= 1'b0;
        end
      endcase
    end
  end

  // FIFO payload storage; shifts on pop, writes the returning beat on push.
  // NOTE: payload storage has no reset; validity is carried entirely by
  // r_fifo_count, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (w_pop_fifo) begin
      r_fifo_data[0] <= r_fifo_data[1];
      r_fifo_resp[0] <= r_fifo_resp[1];
      r_fifo_last[0] <= r_fifo_last[1];
    end
    if (w_push) begin
      r_fifo_data[w_push_idx] <= w_ret_data;
      r_fifo_resp[w_push_idx] <= w_ret_resp;
      r_fifo_last[w_push_idx] <= r_inflight_last;
    end
  end

endmodule

// File: tb/tb_ara_axi_rd_responder.sv
// ----------------------------------------------------------------------------
// tb_ara_axi_rd_responder
//   Directed bench for the AXI read responder. A simple memory model returns
//   {16'hD00D, 32'h0, word_address} one cycle after each mem_req_o, so every
//   expected data value below is written out by hand from the word address.
// ----------------------------------------------------------------------------
module tb_ara_axi_rd_responder;

  logic        clk_i;
  logic        rst_i;
  logic        ar_valid_i;
  logic        ar_ready_o;
  logic [63:0] ar_addr_i;
  logic [4:0]  ar_id_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic        r_valid_o;
  logic        r_ready_i;
  logic [63:0] r_data_o;
  logic [4:0]  r_id_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic [63:0] mem_rdata_i;
  logic        busy_o;

  ara_axi_rd_responder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ar_valid_i  (ar_valid_i),
    .ar_ready_o  (ar_ready_o),
    .ar_addr_i   (ar_addr_i),
    .ar_id_i     (ar_id_i),
    .ar_len_i    (ar_len_i),
    .ar_size_i   (ar_size_i),
    .ar_burst_i  (ar_burst_i),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_data_o    (r_data_o),
    .r_id_o      (r_id_o),
    .r_resp_o    (r_resp_o),
    .r_last_o    (r_last_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Logs collected at each rising edge.
  int          cyc    = 0;
  int          ar_cyc = 0;
  int          rv_cyc = -1;
  int          idle_cyc;
  logic [15:0] q_maddr [$];
  int          q_mcyc  [$];
  logic [63:0] q_data  [$];
  logic [1:0]  q_resp  [$];
  logic        q_last  [$];
  logic [4:0]  q_id    [$];
  int          q_pcyc  [$];

  // Memory with 1-cycle read latency.
  always @(posedge clk_i) begin
    if (mem_req_o) mem_rdata_i <= {16'hD00D, 32'h0, mem_addr_o};
  end

  // Edge monitor: AR handshake, memory requests, first R valid, R pops.
  always @(posedge clk_i) begin
    if (ar_valid_i && ar_ready_o) begin
      ar_cyc <= cyc;
      rv_cyc <= -1;
    end else if (r_valid_o && rv_cyc < 0) begin
      rv_cyc <= cyc;
    end
    if (mem_req_o) begin
      q_maddr.push_back(mem_addr_o);
      q_mcyc.push_back(cyc);
    end
    if (r_valid_o && r_ready_i) begin
      q_data.push_back(r_data_o);
      q_resp.push_back(r_resp_o);
      q_last.push_back(r_last_o);
      q_id.push_back(r_id_o);
      q_pcyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    q_maddr.delete();
    q_mcyc.delete();
    q_data.delete();
    q_resp.delete();
    q_last.delete();
    q_id.delete();
    q_pcyc.delete();
  endtask

  // Present one AR at a falling edge and hold it until accepted.
  task automatic do_ar(input logic [63:0] addr, input logic [4:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit done;
    done       = 1'b0;
    ar_addr_i  = addr;
    ar_id_i    = id;
    ar_len_i   = len;
    ar_size_i  = size;
    ar_burst_i = burst;
    ar_valid_i = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (ar_ready_o) done = 1'b1;
      @(negedge clk_i);
    end
    ar_valid_i = 1'b0;
    check("ar_accepted", 64'(done), 64'd1);
  endtask

  // Wait for the responder to return to IDLE with ar_ready_o asserted.
  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (!busy_o && ar_ready_o) begin
        done     = 1'b1;
        idle_cyc = cyc;
      end else begin
        @(negedge clk_i);
      end
    end
    check({tag, "_idle_timeout"}, 64'(done), 64'd1);
  endtask

  // Compare logged beats with a linear word sequence (step 0 for FIXED).
  task automatic check_beats(input string tag, input int n, input logic [15:0] word0,
                             input int step, input logic [1:0] resp, input logic [4:0] id);
    logic [63:0] exp_data;
    check({tag, "_beats"}, 64'(q_data.size()), 64'(n));
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      exp_data = (resp == 2'b10) ? 64'h0 : {16'hD00D, 32'h0, word0 + 16'(step * i)};
      check($sformatf("%s_data%0d", tag, i), q_data[i], exp_data);
      check($sformatf("%s_resp%0d", tag, i), 64'(q_resp[i]), 64'(resp));
      check($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == n - 1));
      check($sformatf("%s_id%0d", tag, i), 64'(q_id[i]), 64'(id));
    end
  endtask

  initial begin
    int watchdog_dummy;
    watchdog_dummy = 0;
    rst_i      = 1'b1;
    ar_valid_i = 1'b0;
    ar_addr_i  = '0;
    ar_id_i    = '0;
    ar_len_i   = '0;
    ar_size_i  = '0;
    ar_burst_i = '0;
    r_ready_i  = 1'b0;

    // ---- Reset state ------------------------------------------------------
    repeat (3) @(negedge clk_i);
    check("rst_ar_ready", 64'(ar_ready_o), 64'd0);
    check("rst_r_valid",  64'(r_valid_o),  64'd0);
    check("rst_busy",     64'(busy_o),     64'd0);
    check("rst_mem_req",  64'(mem_req_o),  64'd0);
    check("rst_r_data",   r_data_o,        64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ar_ready_after", 64'(ar_ready_o), 64'd1);

    // ---- INCR 0x100, len 3, size 3, id 5, R always ready ------------------
    r_ready_i = 1'b1;
    clear_logs();
    do_ar(64'h100, 5'd5, 8'd3, 3'd3, 2'b01);
    check("incr_busy", 64'(busy_o), 64'd1);
    wait_idle("incr");
    check("incr_nreq", 64'(q_maddr.size()), 64'd4);
    for (int i = 0; i < 4 && i < q_maddr.size(); i++) begin
      check($sformatf("incr_maddr%0d", i), 64'(q_maddr[i]), 64'h20 + 64'(i));
      check($sformatf("incr_mcyc%0d", i), 64'(q_mcyc[i]), 64'(ar_cyc + 1 + i));
    end
    check("incr_first_rvalid", 64'(rv_cyc), 64'(ar_cyc + 2));
    check_beats("incr", 4, 16'h20, 1, 2'b00, 5'd5);
    for (int i = 0; i < 4 && i < q_pcyc.size(); i++)
      check($sformatf("incr_pcyc%0d", i), 64'(q_pcyc[i]), 64'(ar_cyc + 2 + i));

    // ---- WRAP 0x118, len 3, size 3 ----------------------------------------
    clear_logs();
    do_ar(64'h118, 5'd7, 8'd3, 3'd3, 2'b10);
    wait_idle("wrap");
    check("wrap_nreq", 64'(q_maddr.size()), 64'd4);
    if (q_maddr.size() == 4) begin
      check("wrap_maddr0", 64'(q_maddr[0]), 64'h23);
      check("wrap_maddr1", 64'(q_maddr[1]), 64'h20);
      check("wrap_maddr2", 64'(q_maddr[2]), 64'h21);
      check("wrap_maddr3", 64'(q_maddr[3]), 64'h22);
    end
    check("wrap_beats", 64'(q_data.size()), 64'd4);
    if (q_data.size() == 4) begin
      check("wrap_data0", q_data[0], 64'hD00D_0000_0000_0023);
      check("wrap_data1", q_data[1], 64'hD00D_0000_0000_0020);
      check("wrap_data3", q_data[3], 64'hD00D_0000_0000_0022);
      check("wrap_last3", 64'(q_last[3]), 64'd1);
      check("wrap_last2", 64'(q_last[2]), 64'd0);
    end

    // ---- FIXED 0x58, len 2, size 3 ----------------------------------------
    clear_logs();
    do_ar(64'h58, 5'd2, 8'd2, 3'd3, 2'b00);
    wait_idle("fixed");
    check("fixed_nreq", 64'(q_maddr.size()), 64'd3);
    check_beats("fixed", 3, 16'h0B, 0, 2'b00, 5'd2);

    // ---- Backpressure: INCR 0x200, len 7, R stalled for 5 cycles ----------
    r_ready_i = 1'b0;
    clear_logs();
    do_ar(64'h200, 5'd3, 8'd7, 3'd3, 2'b01);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (r_valid_o) seen = 1'b1;
        else @(negedge clk_i);
      end
      check("bp_rvalid_seen", 64'(seen), 64'd1);
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_valid%0d", k), 64'(r_valid_o), 64'd1);
      check($sformatf("bp_hold_data%0d", k), r_data_o, 64'hD00D_0000_0000_0040);
      check($sformatf("bp_hold_last%0d", k), 64'(r_last_o), 64'd0);
      @(negedge clk_i);
    end
    check("bp_nreq_stalled", 64'(q_maddr.size()), 64'd2);
    r_ready_i = 1'b1;
    wait_idle("bp");
    check("bp_nreq", 64'(q_maddr.size()), 64'd8);
    check_beats("bp", 8, 16'h40, 1, 2'b00, 5'd3);

    // ---- Reserved burst type: 3 SLVERR beats, no memory access ------------
    clear_logs();
    do_ar(64'h80, 5'd9, 8'd2, 3'd3, 2'b11);
    wait_idle("rsvd");
    check("rsvd_nreq", 64'(q_maddr.size()), 64'd0);
    check("rsvd_first_rvalid", 64'(rv_cyc), 64'(ar_cyc + 2));
    check_beats("rsvd", 3, 16'h0, 0, 2'b10, 5'd9);
    if (q_pcyc.size() == 3)
      check("rsvd_ar_ready_return", 64'(idle_cyc), 64'(q_pcyc[2] + 1));

    // ---- Illegal WRAP length and oversized beat --------------------------
    clear_logs();
    do_ar(64'h100, 5'd4, 8'd2, 3'd3, 2'b10);
    wait_idle("wrapbad");
    check("wrapbad_nreq", 64'(q_maddr.size()), 64'd0);
    check_beats("wrapbad", 3, 16'h0, 0, 2'b10, 5'd4);
    clear_logs();
    do_ar(64'h100, 5'd6, 8'd0, 3'd4, 2'b01);
    wait_idle("bigsize");
    check("bigsize_nreq", 64'(q_maddr.size()), 64'd0);
    check_beats("bigsize", 1, 16'h0, 0, 2'b10, 5'd6);

    // ---- Reset in the middle of an 8-beat burst ---------------------------
    clear_logs();
    do_ar(64'h300, 5'd1, 8'd7, 3'd3, 2'b01);
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 30 && !hit; k++) begin
        if (q_data.size() == 2) hit = 1'b1;
        else @(negedge clk_i);
      end
      check("mid_rst_reached_beat2", 64'(hit), 64'd1);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_r_valid", 64'(r_valid_o), 64'd0);
    check("mid_rst_busy",    64'(busy_o),    64'd0);
    rst_i = 1'b0;
    clear_logs();
    do_ar(64'h40, 5'd8, 8'd0, 3'd3, 2'b01);
    wait_idle("post_rst");
    repeat (3) @(negedge clk_i);
    check("post_rst_nreq", 64'(q_maddr.size()), 64'd1);
    if (q_maddr.size() == 1) check("post_rst_maddr", 64'(q_maddr[0]), 64'h8);
    check_beats("post_rst", 1, 16'h8, 0, 2'b00, 5'd8);

    // ---- INCR across a 4 KiB page ----------------------------------------
    clear_logs();
    do_ar(64'hFF8, 5'd10, 8'd1, 3'd3, 2'b01);
    wait_idle("page");
`ifdef ARA_AXI_RSP_4K_CHECK_EN
    check("page_nreq", 64'(q_maddr.size()), 64'd0);
    check_beats("page", 2, 16'h0, 0, 2'b10, 5'd10);
`else
    check("page_nreq", 64'(q_maddr.size()), 64'd2);
    if (q_maddr.size() == 2) begin
      check("page_maddr0", 64'(q_maddr[0]), 64'h1FF);
      check("page_maddr1", 64'(q_maddr[1]), 64'h200);
    end
    check_beats("page", 2, 16'h1FF, 1, 2'b00, 5'd10);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule
